addr_demux_seq: RTL and testbench

- Registered, parametrised successor to the 1-to-4 sample-address selector.
- Routes one sample-memory address stream to NUM_CH voice channels. Each channel has a one-entry output slot with a valid/ready handshake.
- Channel comes from an explicit select, or from an internal round-robin scan pointer.
- Sits between the playback address generator and the per-voice sample ROM readers.

---
 rtl/audio_pkg.sv | 15 +
 rtl/demux_slot.sv | 36 +++
 rtl/addr_demux_seq.sv | 79 +++++++
 tb/tb_addr_demux_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the sample-address routing blocks.
package audio_pkg;

  localparam int ADDR_W_DFLT = 16;
  localparam int HOLD_ZERO   = 0;
  localparam int HOLD_LAST   = 1;

  typedef logic [ADDR_W_DFLT-1:0] addr_t;

  // Select width that stays at least one bit wide, even for one or two channels.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output slot: loads on accept, drains on out_ready, 1-cycle latency.
// A load in the same cycle as a drain wins, so out_valid stays high with no bubble.
module demux_slot
  import audio_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int HOLD_MODE = HOLD_ZERO
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr
);

  logic [ADDR_W-1:0] slot;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot      <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      slot      <= load_addr;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      if (HOLD_MODE == HOLD_ZERO) slot <= '0;
    end
  end

  // In hold-last mode an idle channel keeps presenting its last delivered address.
  assign out_addr = (HOLD_MODE == HOLD_LAST || out_valid) ? slot : '0;

endmodule

// File: rtl/addr_demux_seq.sv
// Routes one address stream to NUM_CH one-entry slots by select or round-robin scan.
// Latency 1 cycle; in_ready drops when the target slot is full and not draining.
module addr_demux_seq
  import audio_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int NUM_CH    = 4,
  parameter int HOLD_MODE = HOLD_ZERO,
  parameter int SEL_W     = clog2_min1(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        addr_in,
  input  logic [SEL_W-1:0]         select,
  input  logic                     auto_scan,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_CH*ADDR_W-1:0] out_addr,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic                     sel_err,
  output logic [SEL_W-1:0]         scan_ptr
);

  localparam int NPAD = 1 << SEL_W;

  logic [SEL_W-1:0]  tgt;
  logic              tgt_ok;
  logic              accept;
  logic [NPAD-1:0]   vld_pad;
  logic [NPAD-1:0]   rdy_pad;
  logic [NUM_CH-1:0] load;

  assign tgt    = auto_scan ? scan_ptr : select;
  assign tgt_ok = 32'(tgt) < NUM_CH;

  // Pad to the full select range so out-of-range codes index defined zero bits.
  always_comb begin
    vld_pad             = '0;
    rdy_pad             = '0;
    vld_pad[NUM_CH-1:0] = out_valid;
    rdy_pad[NUM_CH-1:0] = out_ready;
  end

  assign in_ready = reset_n && tgt_ok && (!vld_pad[tgt] || rdy_pad[tgt]);
  assign accept   = in_valid && in_ready;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign load[k] = accept && (tgt == SEL_W'(k));

    demux_slot #(
      .ADDR_W   (ADDR_W),
      .HOLD_MODE(HOLD_MODE)
    ) u_slot (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (load[k]),
      .load_addr(addr_in),
      .out_ready(out_ready[k]),
      .out_valid(out_valid[k]),
      .out_addr (out_addr[k*ADDR_W +: ADDR_W])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_ptr <= '0;
    end else if (accept && auto_scan) begin
      scan_ptr <= (scan_ptr == SEL_W'(NUM_CH - 1)) ? '0 : scan_ptr + 1'b1;
    end
  end

  // Only an explicit select can be out of range; the scan pointer never leaves 0..NUM_CH-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                sel_err <= 1'b0;
    else if (in_valid && !tgt_ok) sel_err <= 1'b1;
  end

endmodule

// File: tb/tb_addr_demux_seq.sv
// Bench: three configurations share one stimulus; each is checked against its own model.
module tb_addr_demux_seq;
  import audio_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  addr_t      addr_in;
  logic [1:0] select;
  logic       auto_scan;
  logic       in_valid;
  logic [3:0] out_ready;

  logic [63:0] out_addr0, out_addr1;
  logic [47:0] out_addr2;
  logic [3:0]  out_valid0, out_valid1;
  logic [2:0]  out_valid2;
  logic        in_ready0, in_ready1, in_ready2;
  logic        sel_err0, sel_err1, sel_err2;
  logic [1:0]  scan0, scan1, scan2;

  int  checks = 0;
  int  errors = 0;
  bit  started = 0;

  always #5 clk = ~clk;

  addr_demux_seq #(.ADDR_W(16), .NUM_CH(4), .HOLD_MODE(0)) u0 (
    .clk(clk), .reset_n(reset_n), .addr_in(addr_in), .select(select),
    .auto_scan(auto_scan), .in_valid(in_valid), .in_ready(in_ready0),
    .out_addr(out_addr0), .out_valid(out_valid0), .out_ready(out_ready),
    .sel_err(sel_err0), .scan_ptr(scan0));

  addr_demux_seq #(.ADDR_W(16), .NUM_CH(4), .HOLD_MODE(1)) u1 (
    .clk(clk), .reset_n(reset_n), .addr_in(addr_in), .select(select),
    .auto_scan(auto_scan), .in_valid(in_valid), .in_ready(in_ready1),
    .out_addr(out_addr1), .out_valid(out_valid1), .out_ready(out_ready),
    .sel_err(sel_err1), .scan_ptr(scan1));

  addr_demux_seq #(.ADDR_W(16), .NUM_CH(3), .HOLD_MODE(0)) u2 (
    .clk(clk), .reset_n(reset_n), .addr_in(addr_in), .select(select),
    .auto_scan(auto_scan), .in_valid(in_valid), .in_ready(in_ready2),
    .out_addr(out_addr2), .out_valid(out_valid2), .out_ready(out_ready[2:0]),
    .sel_err(sel_err2), .scan_ptr(scan2));

  // Model: per instance, which channels hold an undelivered address and what it is.
  int          nch  [3] = '{4, 4, 3};
  int          hold [3] = '{0, 1, 0};
  bit          mv   [3][4];
  logic [15:0] ms   [3][4];
  int          scan_m [3];
  bit          err_m  [3];

  function automatic int m_tgt(int i);
    return auto_scan ? scan_m[i] : int'(select);
  endfunction

  function automatic bit m_rdy(int i);
    int t;
    t = m_tgt(i);
    if (!reset_n || t >= nch[i]) return 1'b0;
    return !mv[i][t] || out_ready[t];
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) begin
        scan_m[i] = 0;
        err_m[i]  = 1'b0;
        for (int k = 0; k < 4; k++) begin
          mv[i][k] = 1'b0;
          ms[i][k] = 16'h0;
        end
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        int t;
        bit acc;
        t   = m_tgt(i);
        acc = in_valid && m_rdy(i);
        for (int k = 0; k < nch[i]; k++) begin
          if (acc && k == t) begin
            mv[i][k] = 1'b1;
            ms[i][k] = addr_in;
          end else if (mv[i][k] && out_ready[k]) begin
            mv[i][k] = 1'b0;
          end
        end
        if (acc && auto_scan) scan_m[i] = (scan_m[i] + 1) % nch[i];
        if (in_valid && !auto_scan && int'(select) >= nch[i]) err_m[i] = 1'b1;
      end
    end
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cmp_inst(int i, logic [63:0] oa, logic [3:0] ov, logic ir, logic se,
                          logic [1:0] sp);
    logic [63:0] ea;
    logic [3:0]  ev;
    ea = '0;
    ev = '0;
    for (int k = 0; k < nch[i]; k++) begin
      ev[k] = mv[i][k];
      if (hold[i] == 1 || mv[i][k]) ea[k*16 +: 16] = ms[i][k];
    end
    chk($sformatf("u%0d out_valid", i), 64'(ov), 64'(ev));
    chk($sformatf("u%0d out_addr", i), oa, ea);
    chk($sformatf("u%0d in_ready", i), 64'(ir), 64'(m_rdy(i)));
    chk($sformatf("u%0d sel_err", i), 64'(se), 64'(err_m[i]));
    chk($sformatf("u%0d scan_ptr", i), 64'(sp), 64'(scan_m[i]));
  endtask

  always @(negedge clk) begin
    if (started) begin
      cmp_inst(0, out_addr0, out_valid0, in_ready0, sel_err0, scan0);
      cmp_inst(1, out_addr1, out_valid1, in_ready1, sel_err1, scan1);
      cmp_inst(2, 64'(out_addr2), 4'(out_valid2), in_ready2, sel_err2, scan2);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b1; addr_in = '0; select = '0; auto_scan = 1'b0;
    in_valid = 1'b0; out_ready = 4'h0;
    #1 reset_n = 1'b0;
    started = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("reset out_valid", 64'(out_valid0), 64'h0);
    chk("reset scan_ptr", 64'(scan0), 64'h0);

    // Directed routing to channel 2.
    cyc();
    select = 2'd2; addr_in = 16'h1234; in_valid = 1'b1; out_ready = 4'hF;
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("route valid", 64'(out_valid0), 64'h4);
    chk("route addr", out_addr0, 64'h0000_1234_0000_0000);

    // Backpressure on channel 1, then same-cycle drain and reload.
    cyc();
    out_ready = 4'h0; select = 2'd1; addr_in = 16'hAAAA; in_valid = 1'b1;
    cyc();
    addr_in = 16'hBBBB;
    @(negedge clk);
    chk("bp in_ready low", 64'(in_ready0), 64'h0);
    chk("bp holds AAAA", 64'(out_addr0[31:16]), 64'hAAAA);
    cyc();
    out_ready = 4'b0010;
    @(negedge clk);
    chk("bp in_ready high", 64'(in_ready0), 64'h1);
    cyc();
    in_valid = 1'b0; out_ready = 4'h0;
    @(negedge clk);
    chk("bp BBBB", 64'(out_addr0[31:16]), 64'hBBBB);
    chk("bp valid", 64'(out_valid0[1]), 64'h1);
    cyc();
    out_ready = 4'hF;
    cyc();

    // Round-robin scan: 0,1,2,3,0,1 on four channels.
    auto_scan = 1'b1;
    for (int i = 0; i < 6; i++) begin
      addr_in = 16'h0010 + 16'(i); in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("scan valid %0d", i), 64'(out_valid0), 64'(1) << (i % 4));
      chk($sformatf("scan addr %0d", i), 64'(out_addr0[(i%4)*16 +: 16]), 64'h10 + 64'(i));
      cyc();
    end
    @(negedge clk);
    chk("scan end u0", 64'(scan0), 64'h2);
    chk("scan end u2", 64'(scan2), 64'h0);

    // Channel 3: hold-mode retention on u1, out-of-range select on u2.
    cyc();
    auto_scan = 1'b0; select = 2'd3; addr_in = 16'h00FF; in_valid = 1'b1; out_ready = 4'h0;
    @(negedge clk);
    chk("oor in_ready", 64'(in_ready2), 64'h0);
    chk("oor err before", 64'(sel_err2), 64'h0);
    cyc();
    in_valid = 1'b0; out_ready = 4'hF;
    @(negedge clk);
    chk("oor err set", 64'(sel_err2), 64'h1);
    chk("oor nothing written", 64'(out_valid2), 64'h0);
    chk("hold loaded", 64'(out_addr1[63:48]), 64'h00FF);
    cyc();
    @(negedge clk);
    chk("hold drained", 64'(out_valid1[3]), 64'h0);
    chk("hold keeps", 64'(out_addr1[63:48]), 64'h00FF);
    chk("zero after drain", 64'(out_addr0[63:48]), 64'h0);
    repeat (100) cyc();
    @(negedge clk);
    chk("oor err sticky", 64'(sel_err2), 64'h1);
    chk("no err pow2", 64'(sel_err0), 64'h0);

    // Mid-stream asynchronous reset with channel 2 occupied.
    cyc();
    select = 2'd2; addr_in = 16'h5555; in_valid = 1'b1; out_ready = 4'h0;
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre-reset ch2", 64'(out_valid0), 64'h4);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst out_valid", 64'(out_valid0), 64'h0);
    chk("rst out_addr", out_addr0, 64'h0);
    chk("rst scan_ptr", 64'(scan0), 64'h0);
    chk("rst in_ready", 64'(in_ready0), 64'h0);
    chk("rst sel_err", 64'(sel_err2), 64'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    cyc();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
